// File: rtl/branch_resolve_unit.sv
// Resolves branch/jump/call/return instructions into registered redirect, link and
// squash-window outputs, with a circular return-address stack for call/return pairs.
module branch_resolve_unit #(
  parameter int ADDR_W       = 21,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  input  logic [2:0]        jump_type,
  input  logic              branch_taken,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic              link,
  output logic [ADDR_W-1:0] link_addr,
  output logic              flush,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PTR_W:0]  RAS_FULL_CNT = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [FC_W-1:0] FC_LAST      = FC_W'(FLUSH_CYCLES - 1);

  localparam logic [2:0] JT_COND   = 3'b001;
  localparam logic [2:0] JT_UNCOND = 3'b010;
  localparam logic [2:0] JT_CALL   = 3'b011;
  localparam logic [2:0] JT_RET    = 3'b100;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [FC_W-1:0] fcnt, fcnt_nxt;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_wptr;
  logic [PTR_W:0]    ras_cnt;

  logic                     vld_p0;
  logic signed [ADDR_W-1:0] off_s_p0;
  logic [ADDR_W-1:0]        rel_tgt_p0;
  logic [ADDR_W-1:0]        link_val_p0;
  logic [ADDR_W-1:0]        ras_top_p0;
  logic [ADDR_W-1:0]        redir_tgt_p0;
  logic                     do_redir_p0, do_link_p0, do_push_p0, do_pop_p0, do_under_p0;

  logic              redirect_p1, link_p1, under_p1;
  logic [ADDR_W-1:0] target_p1, link_addr_p1;

  // Occupancy counter saturates: a push onto a full stack overwrites the oldest slot.
  function automatic logic [PTR_W:0] ras_cnt_inc(input logic [PTR_W:0] c);
    return (c == RAS_FULL_CNT) ? c : c + (PTR_W+1)'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    return a + b;
  endfunction

  // ---- stage p0: decode the accepted instruction ----
  assign vld_p0      = valid_in && (state == IDLE);
  assign off_s_p0    = offset;
  assign rel_tgt_p0  = addr_add(pc, $unsigned(off_s_p0));
  assign link_val_p0 = addr_add(pc, ADDR_W'(1));
  assign ras_top_p0  = ras_mem[ras_wptr - PTR_W'(1)];

  always_comb begin
    do_redir_p0  = 1'b0;
    do_link_p0   = 1'b0;
    do_push_p0   = 1'b0;
    do_pop_p0    = 1'b0;
    do_under_p0  = 1'b0;
    redir_tgt_p0 = rel_tgt_p0;
    if (vld_p0) begin
      case (jump_type)
        JT_COND:   do_redir_p0 = branch_taken;
        JT_UNCOND: do_redir_p0 = 1'b1;
        JT_CALL: begin
          do_redir_p0 = 1'b1;
          do_link_p0  = 1'b1;
          do_push_p0  = 1'b1;
        end
        JT_RET: begin
          if (ras_cnt != '0) begin
            do_redir_p0  = 1'b1;
            do_pop_p0    = 1'b1;
            redir_tgt_p0 = ras_top_p0;
          end else begin
            do_under_p0 = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_p1  <= 1'b0;
      link_p1      <= 1'b0;
      under_p1     <= 1'b0;
      target_p1    <= '0;
      link_addr_p1 <= '0;
    end else begin
      redirect_p1 <= do_redir_p0;
      link_p1     <= do_link_p0;
      under_p1    <= do_under_p0;
      if (do_redir_p0) target_p1    <= redir_tgt_p0;
      if (do_link_p0)  link_addr_p1 <= link_val_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_wptr <= '0;
      ras_cnt  <= '0;
    end else if (do_push_p0) begin
      ras_wptr <= ras_wptr + PTR_W'(1);
      ras_cnt  <= ras_cnt_inc(ras_cnt);
    end else if (do_pop_p0) begin
      ras_wptr <= ras_wptr - PTR_W'(1);
      ras_cnt  <= ras_cnt - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_p0) ras_mem[ras_wptr] <= link_val_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // The redirect cycle is the first flush cycle, so the window starts on the same edge.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      IDLE: begin
        if (do_redir_p0) begin
          state_nxt = FLUSH;
          fcnt_nxt  = '0;
        end
      end
      FLUSH: begin
        if (fcnt == FC_LAST) state_nxt = IDLE;
        else                 fcnt_nxt  = fcnt + FC_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign redirect      = redirect_p1;
  assign target        = target_p1;
  assign link          = link_p1;
  assign link_addr     = link_addr_p1;
  assign ras_underflow = under_p1;
  assign flush         = (state == FLUSH);
  assign ras_empty     = (ras_cnt == '0);
  assign ras_full      = (ras_cnt == RAS_FULL_CNT);

endmodule
